axi_lite_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file, successor to the fixed 4-register memory_ctrl slave interface. Provides NUM_REGS read/write control registers plus NUM_RO read-only status registers, with byte-strobe writes, decoupled AW/W acceptance, SLVERR on out-of-range access and per-register write pulses. Sits between the PS AXI interconnect and the CNN accelerator control/status fabric.

---
 rtl/axi_lite_regfile_pkg.sv | 26 ++
 rtl/axi_lite_regfile_wr_ctrl.sv | 92 +++++++++
 rtl/axi_lite_regfile.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_regfile_pkg.sv
// Shared constants, write-FSM state type and byte-strobe merge helper for axi_lite_regfile.
package axi_lite_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  // Sized for the widest (64-bit) bus; narrower callers extend and truncate around it.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) begin
      res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_regfile_wr_ctrl.sv
// AW/W capture FSM and B channel: accepts address and data in either order, then issues a
// one-cycle commit strobe with the captured index/data/strobe before raising BVALID.
module axi_lite_regfile_wr_ctrl
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 4,
  parameter int unsigned NUM_IDX    = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [IDX_WIDTH-1:0]    awidx_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic                    commit_o,
  output logic [IDX_WIDTH-1:0]    idx_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output logic                    err_o
);

  wr_state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    aw_rdy, w_rdy;
  logic                    aw_hs, w_hs;

  // Readiness is forced low while reset is held, whatever the state register holds.
  assign awready_o = aw_rdy && !rst_i;
  assign wready_o  = w_rdy && !rst_i;
  assign aw_hs     = awvalid_i && awready_o;
  assign w_hs      = wvalid_i && wready_o;

  always_comb begin
    state_d = state_q;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    unique case (state_q)
      W_IDLE: begin
        aw_rdy = 1'b1;
        w_rdy  = 1'b1;
        if (awvalid_i && wvalid_i) state_d = W_COMMIT;
        else if (awvalid_i)        state_d = W_HAVE_AW;
        else if (wvalid_i)         state_d = W_HAVE_W;
      end
      W_HAVE_AW: begin
        w_rdy = 1'b1;
        if (wvalid_i) state_d = W_COMMIT;
      end
      W_HAVE_W: begin
        aw_rdy = 1'b1;
        if (awvalid_i) state_d = W_COMMIT;
      end
      W_COMMIT: state_d = W_RESP;
      W_RESP:   if (bready_i) state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= W_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs) idx_q <= awidx_i;
      if (w_hs) begin
        data_q <= wdata_i;
        strb_q <= wstrb_i;
      end
    end
  end

  assign err_o    = 32'(idx_q) >= NUM_IDX;
  assign commit_o = state_q == W_COMMIT;
  assign idx_o    = idx_q;
  assign data_o   = data_q;
  assign strb_o   = strb_q;
  assign bvalid_o = state_q == W_RESP;
  assign bresp_o  = (bvalid_o && err_o) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file: NUM_REGS R/W control registers plus NUM_RO status registers.
// Define AXI_REGFILE_W1C_EN for sticky write-1-to-clear status; otherwise status reads are live.
module axi_lite_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned NUM_RO     = 4
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]            wr_pulse,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   status_in
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned NUM_IDX    = NUM_REGS + NUM_RO;

  logic                  wr_commit, wr_err;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;

  axi_lite_regfile_wr_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .NUM_IDX    (NUM_IDX)
  ) u_wr_ctrl (
    .clk_i     (S_AXI_ACLK),
    .rst_i     (S_AXI_ARESET),
    .awidx_i   (S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB]),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bresp_o   (S_AXI_BRESP),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .commit_o  (wr_commit),
    .idx_o     (wr_idx),
    .data_o    (wr_data),
    .strb_o    (wr_strb),
    .err_o     (wr_err)
  );

  logic [DATA_WIDTH-1:0] ctrl_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) ctrl_q[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_q[i] <= wr_commit && (wr_idx == IDX_WIDTH'(i));
        if (wr_commit && (wr_idx == IDX_WIDTH'(i))) begin
          ctrl_q[i] <= DATA_WIDTH'(strb_merge(64'(ctrl_q[i]), 64'(wr_data), 8'(wr_strb)));
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl_out
    assign ctrl_regs[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
  end
  assign wr_pulse = wr_pulse_q;

  logic [DATA_WIDTH-1:0] status_val [NUM_RO];

`ifdef AXI_REGFILE_W1C_EN
  logic [DATA_WIDTH-1:0] sticky_q [NUM_RO];
  logic [DATA_WIDTH-1:0] clr_mask;

  assign clr_mask = wr_data & DATA_WIDTH'(strb_merge('0, '1, 8'(wr_strb)));

  // New status bits are OR-ed in after the clear so a same-cycle set survives.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      for (int j = 0; j < NUM_RO; j++) sticky_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_RO; j++) begin
        if (wr_commit && (wr_idx == IDX_WIDTH'(NUM_REGS + j))) begin
          sticky_q[j] <= (sticky_q[j] & ~clr_mask) | status_in[j*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          sticky_q[j] <= sticky_q[j] | status_in[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RO; g++) begin : g_status
    assign status_val[g] = sticky_q[g];
  end
`else
  for (genvar g = 0; g < NUM_RO; g++) begin : g_status
    assign status_val[g] = status_in[g*DATA_WIDTH +: DATA_WIDTH];
  end
`endif

  logic [IDX_WIDTH-1:0]  ar_idx;
  logic [DATA_WIDTH-1:0] rd_data_d, rdata_q;
  logic                  rd_err_d, rvalid_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs;

  assign ar_idx        = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign S_AXI_ARREADY = !S_AXI_ARESET && !rvalid_q;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_WIDTH'(i)) begin
        rd_data_d = ctrl_q[i];
        rd_err_d  = 1'b0;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (ar_idx == IDX_WIDTH'(NUM_REGS + j)) begin
        rd_data_d = status_val[j];
        rd_err_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_d;
      rresp_q  <= rd_err_d ? RESP_SLVERR : RESP_OKAY;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

  logic unused_sigs;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                         S_AXI_ARADDR[ADDR_LSB-1:0], wr_err};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed self-checking bench for axi_lite_regfile (default 32-bit, 8 ctrl + 4 status regs).
module tb_axi_lite_regfile;

  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int NR  = 8;
  localparam int NRO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [NR*DW-1:0]  ctrl_regs;
  logic [NR-1:0]     wr_pulse;
  logic [NRO*DW-1:0] status_in;

  int n_pass  = 0;
  int n_total = 0;
  int pulse_cnt [NR] = '{default: 0};
  logic [DW-1:0] model [NR] = '{default: '0};

  always #5 clk = ~clk;

  axi_lite_regfile #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR),
    .NUM_RO     (NRO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .ctrl_regs     (ctrl_regs),
    .wr_pulse      (wr_pulse),
    .status_in     (status_in)
  );

  // Count high cycles of each write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    end
  end

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic int pulse_sum();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [DW/8-1:0] strb, output logic [1:0] resp);
    int n = 0;
    logic aw_hs, w_hs;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0; n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    resp = bresp;
    if (!bvalid) begin
      n_total++;
      $display("FAIL write_timeout addr=%h: bvalid=0, required 1", addr);
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int n = 0;
    logic hs;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (arvalid && n < 20) begin
      hs = arready;
      @(posedge clk); #1; n++;
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0; n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    data = rdata; resp = rresp;
    if (!rvalid) begin
      n_total++;
      $display("FAIL read_timeout addr=%h: rvalid=0, required 1", addr);
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({awready, wready, arready} !== 3'b000)
      $display("FAIL reset_readies_low: got %b, expected 000", {awready, wready, arready});
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL reset_readies_high: got %b, expected 111", {awready, wready, arready});
    else n_pass++;
    n_total++;
    if ({bvalid, rvalid, bresp, rresp} !== 6'b0)
      $display("FAIL reset_valid_resp: got %b, expected 0", {bvalid, rvalid, bresp, rresp});
    else n_pass++;
    n_total++;
    if (rdata !== '0) $display("FAIL reset_rdata: got %h, expected 0", rdata);
    else n_pass++;
    n_total++;
    if (ctrl_regs !== '0 || wr_pulse !== '0)
      $display("FAIL reset_regs: got %h/%b, expected 0/0", ctrl_regs, wr_pulse);
    else n_pass++;
  endtask

  task automatic test_basic_rw();
    int p0 [NR];
    logic [1:0] resp;
    logic [DW-1:0] d;
    for (int i = 0; i < NR; i++) p0[i] = pulse_cnt[i];
    for (int k = 0; k < 4; k++) begin
      axi_write(AW'(k * 4), DW'(k + 1), 4'hF, resp);
      model[k] = DW'(k + 1);
      n_total++;
      if (resp !== 2'b00) $display("FAIL basic_bresp[%0d]: got %b, expected 00", k, resp);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (pulse_cnt[k] - p0[k] !== 1)
        $display("FAIL basic_pulse[%0d]: got %0d cycles, expected 1", k, pulse_cnt[k] - p0[k]);
      else n_pass++;
      axi_read(AW'(k * 4), d, resp);
      n_total++;
      if (d !== DW'(k + 1) || resp !== 2'b00)
        $display("FAIL basic_read[%0d]: got %h/%b, expected %h/00", k, d, resp, k + 1);
      else n_pass++;
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp;
    int p4;
    axi_write(6'h10, 32'h1122_3344, 4'hF, resp);
    p4 = pulse_cnt[4];
    wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    n_total++;
    if ({wready, awready} !== 2'b01)
      $display("FAIL wfirst_readies: got %b, expected 01", {wready, awready});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    awaddr = 6'h10; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    n_total++;
    if (bvalid !== 1'b0) $display("FAIL wfirst_bvalid_early: got %b, expected 0", bvalid);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bvalid !== 1'b1 || bresp !== 2'b00)
      $display("FAIL wfirst_bvalid: got %b/%b, expected 1/00", bvalid, bresp);
    else n_pass++;
    n_total++;
    if (ctrl_regs[4*DW +: DW] !== 32'h11AD_33EF)
      $display("FAIL wfirst_merge: got %h, expected 11ad33ef", ctrl_regs[4*DW +: DW]);
    else n_pass++;
    n_total++;
    if (wr_pulse !== 8'h10) $display("FAIL wfirst_pulse: got %b, expected 00010000", wr_pulse);
    else n_pass++;
    model[4] = 32'h11AD_33EF;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    n_total++;
    if ({bvalid, awready, wready} !== 3'b011)
      $display("FAIL wfirst_after_b: got %b, expected 011", {bvalid, awready, wready});
    else n_pass++;
    n_total++;
    if (pulse_cnt[4] - p4 !== 1)
      $display("FAIL wfirst_pulse_len: got %0d, expected 1", pulse_cnt[4] - p4);
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic [DW-1:0] d;
    int ps;
    axi_read(6'h3C, d, resp);
    n_total++;
    if (d !== '0 || resp !== 2'b10)
      $display("FAIL oor_read: got %h/%b, expected 0/10", d, resp);
    else n_pass++;
    ps = pulse_sum();
    axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, resp);
    n_total++;
    if (resp !== 2'b10) $display("FAIL oor_bresp: got %b, expected 10", resp);
    else n_pass++;
    axi_write(6'h20, 32'h0000_0000, 4'hF, resp);
    n_total++;
    if (resp !== 2'b00) $display("FAIL ro_bresp: got %b, expected 00", resp);
    else n_pass++;
    n_total++;
    if (ctrl_regs !== model_flat() || pulse_sum() !== ps)
      $display("FAIL oor_no_effect: got %h pulses+%0d, expected %h pulses+0",
               ctrl_regs, pulse_sum() - ps, model_flat());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n = 0;
    awaddr = 6'h14; wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    while (!bvalid && n < 10) begin @(posedge clk); #1; n++; end
    model[5] = 32'hA5A5_5A5A;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({bvalid, bresp, awready, wready} !== 5'b1_00_0_0)
        $display("FAIL bp_b_hold[%0d]: got %b, expected 10000", c,
                 {bvalid, bresp, awready, wready});
      else n_pass++;
      @(posedge clk); #1;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    araddr = 6'h14; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'hA5A5_5A5A})
        $display("FAIL bp_r_hold[%0d]: got %b/%b/%b/%h, expected 1/0/00/a5a55a5a", c,
                 rvalid, arready, rresp, rdata);
      else n_pass++;
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    n_total++;
    if ({rvalid, arready} !== 2'b01)
      $display("FAIL bp_r_release: got %b, expected 01", {rvalid, arready});
    else n_pass++;
  endtask

  task automatic test_same_cycle_rw();
    logic [1:0] resp;
    logic [DW-1:0] d;
    int p6;
    axi_write(6'h18, 32'hAAAA_0000, 4'hF, resp);
    awaddr = 6'h18; wdata = 32'h0000_5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h18; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    n_total++;
    if (rvalid !== 1'b1 || rdata !== 32'hAAAA_0000)
      $display("FAIL rw_collide: got %b/%h, expected 1/aaaa0000", rvalid, rdata);
    else n_pass++;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    model[6] = 32'h0000_5555;
    axi_read(6'h18, d, resp);
    n_total++;
    if (d !== 32'h0000_5555) $display("FAIL rw_after: got %h, expected 00005555", d);
    else n_pass++;
    p6 = pulse_cnt[6];
    axi_write(6'h18, 32'hFFFF_FFFF, 4'h0, resp);
    axi_read(6'h18, d, resp);
    n_total++;
    if (d !== 32'h0000_5555 || resp !== 2'b00)
      $display("FAIL strb_zero_data: got %h/%b, expected 00005555/00", d, resp);
    else n_pass++;
    n_total++;
    if (pulse_cnt[6] - p6 !== 1)
      $display("FAIL strb_zero_pulse: got %0d, expected 1", pulse_cnt[6] - p6);
    else n_pass++;
  endtask

`ifdef AXI_REGFILE_W1C_EN
  task automatic test_status();
    logic [1:0] resp;
    logic [DW-1:0] d;
    status_in = '0;
    status_in[0] = 1'b1;
    @(posedge clk); #1;
    status_in[0] = 1'b0;
    axi_read(6'h20, d, resp);
    n_total++;
    if (d !== 32'h1 || resp !== 2'b00) $display("FAIL w1c_set: got %h/%b, expected 1/00", d, resp);
    else n_pass++;
    axi_write(6'h20, 32'h1, 4'hF, resp);
    axi_read(6'h20, d, resp);
    n_total++;
    if (d !== 32'h0) $display("FAIL w1c_clear: got %h, expected 0", d);
    else n_pass++;
    awaddr = 6'h20; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; status_in[0] = 1'b1;
    @(posedge clk); #1;
    status_in[0] = 1'b0;
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(6'h20, d, resp);
    n_total++;
    if (d !== 32'h1) $display("FAIL w1c_set_wins: got %h, expected 1", d);
    else n_pass++;
    status_in[8] = 1'b1;
    @(posedge clk); #1;
    status_in[8] = 1'b0;
    axi_write(6'h20, 32'h0000_0101, 4'b0001, resp);
    axi_read(6'h20, d, resp);
    n_total++;
    if (d !== 32'h0000_0100) $display("FAIL w1c_strobed: got %h, expected 00000100", d);
    else n_pass++;
  endtask
`else
  task automatic test_status();
    logic [1:0] resp;
    logic [DW-1:0] d;
    status_in[0*DW +: DW] = 32'hCAFE_F00D;
    status_in[3*DW +: DW] = 32'h0BAD_BEEF;
    axi_read(6'h20, d, resp);
    n_total++;
    if (d !== 32'hCAFE_F00D || resp !== 2'b00)
      $display("FAIL status_r8: got %h/%b, expected cafef00d/00", d, resp);
    else n_pass++;
    axi_read(6'h2C, d, resp);
    n_total++;
    if (d !== 32'h0BAD_BEEF) $display("FAIL status_r11: got %h, expected 0badbeef", d);
    else n_pass++;
    status_in[1*DW +: DW] = 32'h1234_5678;
    araddr = 6'h24; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    status_in[1*DW +: DW] = 32'h0;
    @(posedge clk); #1;
    n_total++;
    if (rdata !== 32'h1234_5678)
      $display("FAIL status_sampled: got %h, expected 12345678", rdata);
    else n_pass++;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [DW-1:0] d;
    int ps;
    araddr = 6'h00; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    ps = pulse_sum();
    awaddr = 6'h04; awvalid = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({awready, wready, arready} !== 3'b000)
      $display("FAIL mid_reset_readies: got %b, expected 000", {awready, wready, arready});
    else n_pass++;
    awvalid = 1'b0; rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_total++;
      if ({bvalid, rvalid} !== 2'b00)
        $display("FAIL mid_no_late_valid[%0d]: got %b, expected 00", c, {bvalid, rvalid});
      else n_pass++;
    end
    n_total++;
    if (ctrl_regs !== '0 || pulse_sum() !== ps)
      $display("FAIL mid_no_write: got %h pulses+%0d, expected 0 pulses+0",
               ctrl_regs, pulse_sum() - ps);
    else n_pass++;
    axi_write(6'h04, 32'h0000_0077, 4'hF, resp);
    axi_read(6'h04, d, resp);
    n_total++;
    if (d !== 32'h77 || resp !== 2'b00)
      $display("FAIL mid_recover: got %h/%b, expected 00000077/00", d, resp);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0; status_in = '0;
    test_reset();
    test_basic_rw();
    test_w_before_aw();
    test_out_of_range();
    test_backpressure();
    test_same_cycle_rw();
    test_status();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200000, expected finish earlier");
    $fatal(1);
  end

endmodule
